// File: rtl/icache_assoc_array_if.sv
// ---------------------------------------------------------------------------
// icache_assoc_array_if
//
// Request/response and flush signals between the fetch side (master) and the
// set-associative icache storage array (slave).
//
//   req_valid     fetch -> array  request present
//   req_fill      fetch -> array  1 = fill (write), 0 = read
//   addr          fetch -> array  request address, word aligned
//   fill_block    fetch -> array  line data for a fill
//   flush_req     fetch -> array  single-cycle flush pulse
//   ready         array -> fetch  request accepted when req_valid & ready
//   flush_busy    array -> fetch  flush walk in progress
//   rsp_valid     array -> fetch  response for last cycle's request
//   hit           array -> fetch  response hit (always 1 for fills)
//   rd_block      array -> fetch  hit/fill line data, 0 on miss
//   rd_block_mask array -> fetch  words at or above the address word offset
//   hit_cnt       array -> fetch  read-hit counter (ICACHE_ARRAY_PERF_EN only)
//   miss_cnt      array -> fetch  read-miss counter (ICACHE_ARRAY_PERF_EN only)
// ---------------------------------------------------------------------------
interface icache_assoc_array_if #(
  parameter int XLEN        = 32,
  parameter int BLOCK_BYTES = 32
`ifdef ICACHE_ARRAY_PERF_EN
  , parameter int CNT_W     = 32
`endif
);
  localparam int WORDS = BLOCK_BYTES / 4;

  logic                     req_valid;
  logic                     req_fill;
  logic [XLEN-1:0]          addr;
  logic [8*BLOCK_BYTES-1:0] fill_block;
  logic                     flush_req;
  logic                     ready;
  logic                     flush_busy;
  logic                     rsp_valid;
  logic                     hit;
  logic [8*BLOCK_BYTES-1:0] rd_block;
  logic [WORDS-1:0]         rd_block_mask;
`ifdef ICACHE_ARRAY_PERF_EN
  logic [CNT_W-1:0]         hit_cnt;
  logic [CNT_W-1:0]         miss_cnt;
`endif

  modport master (
    output req_valid, req_fill, addr, fill_block, flush_req,
    input  ready, flush_busy, rsp_valid, hit, rd_block, rd_block_mask
`ifdef ICACHE_ARRAY_PERF_EN
    , input hit_cnt, miss_cnt
`endif
  );

  modport slave (
    input  req_valid, req_fill, addr, fill_block, flush_req,
    output ready, flush_busy, rsp_valid, hit, rd_block, rd_block_mask
`ifdef ICACHE_ARRAY_PERF_EN
    , output hit_cnt, miss_cnt
`endif
  );
endinterface

// File: rtl/icache_assoc_array.sv
// ---------------------------------------------------------------------------
// icache_assoc_array
//
// Parametrised set-associative instruction-cache storage array. Per-way tag
// and data SRAMs (single port, written on fills only), valid and tree-PLRU
// bits in flops, invalid-way-first fill, one-cycle registered responses and a
// sequential whole-cache flush walker (one set per cycle).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    icache_assoc_array_if.slave (request, response, flush, counters)
//
// Optional feature macro: ICACHE_ARRAY_PERF_EN adds saturating read hit/miss
// counters (hit_cnt/miss_cnt on the interface), cleared on flush start.
// ---------------------------------------------------------------------------
module icache_assoc_array #(
  parameter int XLEN        = 32,
  parameter int WAYS        = 4,
  parameter int SETS        = 64,
  parameter int BLOCK_BYTES = 32
`ifdef ICACHE_ARRAY_PERF_EN
  , parameter int CNT_W     = 32
`endif
) (
  input logic                 clk,
  input logic                 rst_n,
  icache_assoc_array_if.slave bus
);
  localparam int OFF_W  = $clog2(BLOCK_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = XLEN - OFF_W - IDX_W;
  localparam int WORDS  = BLOCK_BYTES / 4;
  localparam int LOGW   = $clog2(WAYS);
  localparam int LINE_W = 8 * BLOCK_BYTES;

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [IDX_W-1:0]  r_flushIdx;
  logic              w_flushStart;
  logic              w_accept;

  logic [TAG_W-1:0]  r_tagMem  [WAYS][SETS];
  logic [LINE_W-1:0] r_dataMem [WAYS][SETS];
  logic [WAYS-1:0]   r_valid   [SETS];
  logic [WAYS-2:0]   r_plru    [SETS];

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;

  logic              r_rspValid;
  logic              r_rspFill;
  logic [IDX_W-1:0]  r_idx;
  logic [TAG_W-1:0]  r_tag;
  logic [OFF_W-1:0]  r_off;
  logic [WAYS-1:0]   r_validRd;
  logic [LINE_W-1:0] r_fillData;
  logic [TAG_W-1:0]  r_tagRd  [WAYS];
  logic [LINE_W-1:0] r_dataRd [WAYS];

  logic              w_readHit;
  logic [LOGW-1:0]   w_hitWay;
  logic [LINE_W-1:0] w_hitData;
  logic              w_rspHit;
  logic [WAYS-2:0]   w_plruCur;
  logic [LOGW-1:0]   w_victim;
  logic [WORDS-1:0]  w_mask;

  // Heap-ordered tree: node n has children 2n+1 (lower) and 2n+2 (upper).
  // Touching a way points every node on its path at the opposite subtree.
  function automatic logic [WAYS-2:0] plruTouch(input logic [WAYS-2:0] p,
                                                input logic [LOGW-1:0] way);
    logic [WAYS-2:0] q;
    int node;
    q    = p;
    node = 0;
    for (int l = 0; l < LOGW; l++) begin
      for (int k = 0; k < WAYS - 1; k++)
        if (k == node) q[k] = ~way[LOGW-1-l];
      node = 2 * node + 1 + int'(way[LOGW-1-l]);
    end
    return q;
  endfunction

  // Walk the tree from the root following node bits (0 = lower subtree).
  function automatic logic [LOGW-1:0] plruVictim(input logic [WAYS-2:0] p);
    logic [LOGW-1:0] way;
    logic b;
    int node;
    way  = '0;
    node = 0;
    for (int l = 0; l < LOGW; l++) begin
      b = 1'b0;
      for (int k = 0; k < WAYS - 1; k++)
        if (k == node) b = p[k];
      way[LOGW-1-l] = b;
      node = 2 * node + 1 + int'(b);
    end
    return way;
  endfunction

  assign w_idx    = bus.addr[OFF_W +: IDX_W];
  assign w_tag    = bus.addr[XLEN-1 -: TAG_W];
  assign w_accept = bus.req_valid && (r_state == IDLE);

  always_comb begin
    w_stateNext  = r_state;
    w_flushStart = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.flush_req) begin
          w_stateNext  = FLUSH;
          w_flushStart = 1'b1;
        end
      end
      FLUSH: begin
        if (r_flushIdx == IDX_W'(SETS - 1)) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_flushIdx <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_flushStart)
        r_flushIdx <= '0;
      else if (r_state == FLUSH)
        r_flushIdx <= r_flushIdx + IDX_W'(1);
    end
  end

  // Hit detection uses the valid bits and SRAM tags captured at accept.
  always_comb begin
    w_readHit = 1'b0;
    w_hitWay  = '0;
    w_hitData = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_rspValid && !r_rspFill && r_validRd[w] && (r_tagRd[w] == r_tag)) begin
        w_readHit = 1'b1;
        w_hitWay  = LOGW'(w);
        w_hitData = w_hitData | r_dataRd[w];
      end
    end
  end

  // A read hit committing this cycle to the same set must be seen by the
  // fill's victim choice, otherwise the fill could evict the line just used.
  always_comb begin
    w_plruCur = r_plru[w_idx];
    if (w_readHit && (r_idx == w_idx))
      w_plruCur = plruTouch(r_plru[r_idx], w_hitWay);
    w_victim = plruVictim(w_plruCur);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!r_valid[w_idx][w]) w_victim = LOGW'(w);
  end

  // Later assignments win: the fill update already folds in a same-set hit,
  // and the flush clear overrides a hit update landing in its first cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      if (w_readHit)
        r_plru[r_idx] <= plruTouch(r_plru[r_idx], w_hitWay);
      if (w_accept && bus.req_fill) begin
        r_valid[w_idx][w_victim] <= 1'b1;
        r_plru[w_idx]            <= plruTouch(w_plruCur, w_victim);
      end
      if (r_state == FLUSH) begin
        r_valid[r_flushIdx] <= '0;
        r_plru[r_flushIdx]  <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int w = 0; w < WAYS; w++) begin
        if (bus.req_fill) begin
          if (w_victim == LOGW'(w)) begin
            r_tagMem[w][w_idx]  <= w_tag;
            r_dataMem[w][w_idx] <= bus.fill_block;
          end
        end else begin
          r_tagRd[w]  <= r_tagMem[w][w_idx];
          r_dataRd[w] <= r_dataMem[w][w_idx];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rspValid <= 1'b0;
      r_rspFill  <= 1'b0;
      r_idx      <= '0;
      r_tag      <= '0;
      r_off      <= '0;
      r_validRd  <= '0;
      r_fillData <= '0;
    end else begin
      r_rspValid <= w_accept;
      if (w_accept) begin
        r_rspFill <= bus.req_fill;
        r_idx     <= w_idx;
        r_tag     <= w_tag;
        r_off     <= bus.addr[OFF_W-1:0];
        r_validRd <= r_valid[w_idx];
        if (bus.req_fill) r_fillData <= bus.fill_block;
      end
    end
  end

  assign w_rspHit = w_readHit || (r_rspValid && r_rspFill);

  // Offsets are word aligned, so comparing word numbers is exact.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < WORDS; i++)
      w_mask[i] = w_rspHit && ((r_off >> 2) <= OFF_W'(i));
  end

  assign bus.ready         = (r_state == IDLE);
  assign bus.flush_busy    = (r_state == FLUSH);
  assign bus.rsp_valid     = r_rspValid;
  assign bus.hit           = w_rspHit;
  assign bus.rd_block      = (r_rspValid && r_rspFill) ? r_fillData : w_hitData;
  assign bus.rd_block_mask = w_mask;

`ifdef ICACHE_ARRAY_PERF_EN
  logic [CNT_W-1:0] r_hitCnt;
  logic [CNT_W-1:0] r_missCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hitCnt  <= '0;
      r_missCnt <= '0;
    end else if (w_flushStart) begin
      r_hitCnt  <= '0;
      r_missCnt <= '0;
    end else if (r_rspValid && !r_rspFill) begin
      if (w_readHit) begin
        if (r_hitCnt != '1) r_hitCnt <= r_hitCnt + CNT_W'(1);
      end else begin
        if (r_missCnt != '1) r_missCnt <= r_missCnt + CNT_W'(1);
      end
    end
  end

  assign bus.hit_cnt  = r_hitCnt;
  assign bus.miss_cnt = r_missCnt;
`endif

  addrAligned: assert property (@(posedge clk) disable iff (!rst_n)
    bus.req_valid |-> (bus.addr[1:0] == 2'b00));

endmodule

// File: tb/tb_icache_assoc_array.sv
// ---------------------------------------------------------------------------
// tb_icache_assoc_array
//
// Directed self-checking bench for icache_assoc_array at default parameters
// (4 ways, 64 sets, 32-byte lines). Inputs are driven on the falling edge, so
// at each falling edge the outputs show the response to the request accepted
// at the preceding rising edge.
// ---------------------------------------------------------------------------
module tb_icache_assoc_array;
  logic clk;
  logic rst_n;
  int   compareCount;
  int   failCount;
  int   busyCycles;
  int   readyLow;

  icache_assoc_array_if bus ();

  icache_assoc_array dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] mkBlock(input int k);
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[32*i +: 32] = 32'hC0DE0000 + 32'(k * 16 + i);
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] obs,
                             input logic [255:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic checkRsp(input string name, input logic expHit,
                          input logic [255:0] expBlock, input logic [7:0] expMask);
    checkOutput({name, ".rsp_valid"}, 256'(bus.rsp_valid), 256'(1));
    checkOutput({name, ".hit"}, 256'(bus.hit), 256'(expHit));
    checkOutput({name, ".rd_block"}, bus.rd_block, expBlock);
    checkOutput({name, ".mask"}, 256'(bus.rd_block_mask), 256'(expMask));
  endtask

  task automatic applyStimulus(input logic valid, input logic fill,
                               input logic [31:0] addr, input logic [255:0] data,
                               input logic flush);
    @(negedge clk);
    bus.req_valid  = valid;
    bus.req_fill   = fill;
    bus.addr       = addr;
    bus.fill_block = data;
    bus.flush_req  = flush;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_fill   = 1'b0;
    bus.addr       = '0;
    bus.fill_block = '0;
    bus.flush_req  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Counts falling edges with flush_busy high, bounded so a stuck walk ends.
  task automatic measureFlush();
    busyCycles = 0;
    readyLow   = 0;
    for (int i = 0; i < 200; i++) begin
      if (!bus.flush_busy) break;
      busyCycles++;
      if (!bus.ready) readyLow++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clk          = 1'b0;
    rst_n        = 1'b0;
    compareCount = 0;
    failCount    = 0;
    doReset();

    // Reset state
    checkOutput("rst.ready", 256'(bus.ready), 256'(1));
    checkOutput("rst.flush_busy", 256'(bus.flush_busy), 256'(0));
    checkOutput("rst.rsp_valid", 256'(bus.rsp_valid), 256'(0));
    checkOutput("rst.hit", 256'(bus.hit), 256'(0));
    checkOutput("rst.rd_block", bus.rd_block, 256'(0));
    checkOutput("rst.mask", 256'(bus.rd_block_mask), 256'(0));

    // Cold read misses
    applyStimulus(1, 0, 32'h1000, '0, 0);
    applyStimulus(0, 0, 32'h0, '0, 0);
    checkRsp("coldRead", 0, '0, 8'h00);

    // Fill then read-after-fill at several word offsets
    applyStimulus(1, 1, 32'h1000, mkBlock(1), 0);
    applyStimulus(1, 0, 32'h1004, '0, 0);
    checkRsp("fill1000", 1, mkBlock(1), 8'hFF);
    applyStimulus(1, 0, 32'h101C, '0, 0);
    checkRsp("read1004", 1, mkBlock(1), 8'hFE);
    applyStimulus(0, 0, 32'h0, '0, 0);
    checkRsp("read101C", 1, mkBlock(1), 8'h80);
    applyStimulus(0, 0, 32'h0, '0, 0);
    checkOutput("idle.rsp_valid", 256'(bus.rsp_valid), 256'(0));

    // Invalid-first fill of set 0, PLRU eviction, bypassed victim choice
    doReset();
    applyStimulus(1, 1, 32'h0000, mkBlock(10), 0);
    applyStimulus(1, 1, 32'h0800, mkBlock(11), 0);
    applyStimulus(1, 1, 32'h1000, mkBlock(12), 0);
    applyStimulus(1, 1, 32'h1800, mkBlock(13), 0);
    applyStimulus(1, 1, 32'h2000, mkBlock(14), 0);
    applyStimulus(1, 0, 32'h0000, '0, 0);
    checkRsp("fill2000", 1, mkBlock(14), 8'hFF);
    applyStimulus(1, 0, 32'h0800, '0, 0);
    checkRsp("evicted0000", 0, '0, 8'h00);
    applyStimulus(1, 0, 32'h1800, '0, 0);
    checkRsp("read0800", 1, mkBlock(11), 8'hFF);
    applyStimulus(1, 1, 32'h2800, mkBlock(15), 0);
    checkRsp("read1800", 1, mkBlock(13), 8'hFF);
    applyStimulus(1, 0, 32'h2000, '0, 0);
    checkRsp("fill2800", 1, mkBlock(15), 8'hFF);
    applyStimulus(1, 0, 32'h1000, '0, 0);
    checkRsp("evicted2000", 0, '0, 8'h00);
    applyStimulus(1, 0, 32'h2800, '0, 0);
    checkRsp("kept1000", 1, mkBlock(12), 8'hFF);
    applyStimulus(0, 0, 32'h0, '0, 0);
    checkRsp("read2800", 1, mkBlock(15), 8'hFF);

    // Whole-cache flush walk length and invalidation
    doReset();
    applyStimulus(1, 1, 32'h0000, mkBlock(20), 0);
    applyStimulus(1, 1, 32'h0020, mkBlock(21), 0);
    applyStimulus(0, 0, 32'h0, '0, 1);
    applyStimulus(0, 0, 32'h0, '0, 0);
    measureFlush();
    checkOutput("flush.busyCycles", 256'(busyCycles), 256'(64));
    checkOutput("flush.readyLow", 256'(readyLow), 256'(64));
    checkOutput("flush.readyAfter", 256'(bus.ready), 256'(1));
    applyStimulus(1, 0, 32'h0000, '0, 0);
    applyStimulus(1, 0, 32'h0020, '0, 0);
    checkRsp("flushed0000", 0, '0, 8'h00);
    applyStimulus(0, 0, 32'h0, '0, 0);
    checkRsp("flushed0020", 0, '0, 8'h00);

    // Fill together with flush_req: fill completes, then gets flushed
    applyStimulus(1, 1, 32'h0040, mkBlock(30), 1);
    applyStimulus(0, 0, 32'h0, '0, 0);
    checkRsp("fillDuringFlushReq", 1, mkBlock(30), 8'hFF);
    checkOutput("fillFlush.busy", 256'(bus.flush_busy), 256'(1));
    measureFlush();
    checkOutput("fillFlush.busyCycles", 256'(busyCycles), 256'(64));
    applyStimulus(1, 0, 32'h0040, '0, 0);
    applyStimulus(0, 0, 32'h0, '0, 0);
    checkRsp("flushed0040", 0, '0, 8'h00);

    // Reset in the middle of a flush walk
    applyStimulus(1, 1, 32'h1000, mkBlock(40), 0);
    applyStimulus(0, 0, 32'h0, '0, 1);
    repeat (10) @(negedge clk);
    bus.flush_req = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midReset.busy", 256'(bus.flush_busy), 256'(0));
    checkOutput("midReset.ready", 256'(bus.ready), 256'(1));
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 0, 32'h1000, '0, 0);
    applyStimulus(0, 0, 32'h0, '0, 0);
    checkRsp("afterMidReset", 0, '0, 8'h00);
    checkOutput("afterMidReset.busy", 256'(bus.flush_busy), 256'(0));

`ifdef ICACHE_ARRAY_PERF_EN
    // Read hit/miss counters; fills not counted; cleared by flush start
    doReset();
    applyStimulus(1, 1, 32'h0000, mkBlock(50), 0);
    applyStimulus(1, 0, 32'h0000, '0, 0);
    applyStimulus(1, 0, 32'h0800, '0, 0);
    applyStimulus(1, 0, 32'h0004, '0, 0);
    applyStimulus(1, 0, 32'h1800, '0, 0);
    applyStimulus(1, 0, 32'h0008, '0, 0);
    applyStimulus(0, 0, 32'h0, '0, 0);
    applyStimulus(0, 0, 32'h0, '0, 0);
    checkOutput("perf.hit_cnt", 256'(bus.hit_cnt), 256'(3));
    checkOutput("perf.miss_cnt", 256'(bus.miss_cnt), 256'(2));
    applyStimulus(0, 0, 32'h0, '0, 1);
    applyStimulus(0, 0, 32'h0, '0, 0);
    checkOutput("perf.hit_cnt.flushed", 256'(bus.hit_cnt), 256'(0));
    checkOutput("perf.miss_cnt.flushed", 256'(bus.miss_cnt), 256'(0));
    measureFlush();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end
endmodule
